// File: rtl/gcd_pkg.sv
// Shared types and default widths for the GCD job sequencer and its job queue.
package gcd_pkg;

  localparam int OPW_DEF  = 12;
  localparam int CNTW_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RUN     = 3'd2,
    ST_WAITLOW = 3'd3,
    ST_REPORT  = 3'd4
  } gcd_state_e;

endpackage

// File: rtl/gcd_job_fifo.sv
// Circular job queue with wrapping pointers; push and pop strobes arrive already
// qualified by the clock enable, and a push into a full queue is always refused.
module gcd_job_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 13
) (
  input  logic                     CLK,
  input  logic                     RESETn,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Fullness is judged before the pop, so a same-cycle pop never frees a slot early.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gcd_job_seq.sv
// Sequences queued GCD jobs onto a single core: start pulse, cycle counting with
// timeout, single-entry result slot and a sticky interrupt.
module gcd_job_seq
  import gcd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int OPW     = OPW_DEF,
  parameter int CNTW    = CNTW_DEF,
  parameter int TIMEOUT = 4095
) (
  input  logic                      CLK,
  input  logic                      RESETn,
  input  logic                      CLKEN,
  // Handshakes: a transfer happens on an enabled edge where valid and ready are
  // both 1; valid holds its payload until accepted, ready may change freely.
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [OPW-1:0]            job_opcode,
  input  logic                      job_ct,
  output logic                      core_start,
  output logic [OPW-1:0]            core_opcode,
  output logic                      core_ct,
  input  logic                      core_done,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [OPW-1:0]            res_opcode,
  output logic [CNTW-1:0]           res_cycles,
  output logic                      res_timeout,
  output logic                      irq,
  input  logic                      irq_en,
  input  logic                      irq_clr,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    pending,
  output gcd_state_e                dbg_state
);

  localparam int FW = OPW + 1;
  localparam logic [CNTW-1:0] TO_LIM = CNTW'(TIMEOUT);

  gcd_state_e     state_q;
  logic           start_q;
  logic [OPW-1:0] op_q;
  logic           ct_q;
  logic           done_r_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cap_cyc_q;
  logic           cap_to_q;
  logic           cap_pend_q;
  logic           res_valid_q;
  logic [OPW-1:0] res_op_q;
  logic [CNTW-1:0] res_cyc_q;
  logic           res_to_q;
  logic           irq_q;

  logic           fifo_full;
  logic           fifo_empty;
  logic [FW-1:0]  fifo_rdata;
  logic           job_push;
  logic           fifo_pop;
  logic           res_pop;
  logic           done_rise;
  logic           load_res;
  logic [CNTW-1:0] cnt_inc;

  gcd_job_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .CLK     (CLK),
    .RESETn  (RESETn),
    .push_i  (job_push),
    .wdata_i ({job_ct, job_opcode}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (pending)
  );

  // Ready is forced low for the whole reset and rises as soon as reset releases.
  assign job_ready = RESETn & ~fifo_full;
  assign job_push  = CLKEN & job_valid & job_ready;
  assign fifo_pop  = CLKEN & (state_q == ST_IDLE) & ~fifo_empty & ~core_done;
  assign res_pop   = CLKEN & res_valid_q & res_ready;
  assign done_rise = core_done & ~done_r_q;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // A captured result moves into the slot only once the slot has drained.
  assign load_res  = CLKEN & cap_pend_q & ~res_valid_q &
                     ((state_q == ST_REPORT) | (state_q == ST_WAITLOW));

  assign core_start  = start_q & CLKEN;
  assign core_opcode = op_q;
  assign core_ct     = ct_q;
  assign res_valid   = res_valid_q;
  assign res_opcode  = res_op_q;
  assign res_cycles  = res_cyc_q;
  assign res_timeout = res_to_q;
  assign irq         = irq_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      op_q        <= '0;
      ct_q        <= 1'b0;
      done_r_q    <= 1'b0;
      cnt_q       <= '0;
      cap_cyc_q   <= '0;
      cap_to_q    <= 1'b0;
      cap_pend_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_op_q    <= '0;
      res_cyc_q   <= '0;
      res_to_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else if (CLKEN) begin
      done_r_q <= core_done;
      start_q  <= 1'b0;

      if (res_pop) res_valid_q <= 1'b0;
      if (load_res) begin
        res_valid_q <= 1'b1;
        res_op_q    <= op_q;
        res_cyc_q   <= cap_cyc_q;
        res_to_q    <= cap_to_q;
        cap_pend_q  <= 1'b0;
      end

      // Setting wins over a simultaneous clear.
      if (load_res && irq_en) irq_q <= 1'b1;
      else if (irq_clr)       irq_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            op_q    <= fifo_rdata[OPW-1:0];
            ct_q    <= fifo_rdata[OPW];
            start_q <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          cnt_q   <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          cnt_q <= cnt_inc;
          // The cycle that sees the done edge is itself counted.
          if (done_rise) begin
            cap_cyc_q  <= cnt_inc;
            cap_to_q   <= 1'b0;
            cap_pend_q <= 1'b1;
            state_q    <= ST_REPORT;
          end else if (cnt_inc == TO_LIM) begin
            cap_cyc_q  <= cnt_inc;
            cap_to_q   <= 1'b1;
            cap_pend_q <= 1'b1;
            state_q    <= ST_WAITLOW;
          end
        end
        ST_WAITLOW: begin
          if (!core_done && !res_valid_q && !cap_pend_q) state_q <= ST_IDLE;
        end
        ST_REPORT: begin
          if (load_res) state_q <= core_done ? ST_WAITLOW : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
